// File: rtl/bus_target_burst.sv
// Memory-backed bus target: window decode, read wait states, incrementing bursts,
// error response on decode miss, and an inter-beat write timeout.
module bus_target_burst #(
    parameter int          DATA_WIDTH     = 8,
    parameter int          MEM_ADDR_WIDTH = 8,
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter int          READ_LATENCY   = 1,
    parameter int          WR_TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           target_addr_in,
    input  logic                  target_addr_in_valid,
    input  logic                  target_rw,
    input  logic [3:0]            target_burst_len,
    input  logic [DATA_WIDTH-1:0] target_data_in,
    input  logic                  target_data_in_valid,
    output logic [DATA_WIDTH-1:0] target_data_out,
    output logic                  target_data_out_valid,
    output logic                  target_ack,
    output logic                  target_err,
    output logic                  target_ready
);

    localparam int          DEPTH    = 1 << MEM_ADDR_WIDTH;
    localparam logic [15:0] LAT_INIT = (READ_LATENCY > 1) ? 16'(READ_LATENCY - 2) : 16'd0;
    localparam logic [15:0] TO_LIM   = 16'(WR_TIMEOUT);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, RESP_ERR} state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [4:0]                left_q, left_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]     dout_q, dout_d;
    logic                      dvld_q, dvld_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic                      ready_q, ready_d;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];
    logic                      mem_we;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr;
    logic                      hit;

    assign hit = (target_addr_in >> MEM_ADDR_WIDTH) == (BASE_ADDR >> MEM_ADDR_WIDTH);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        left_d    = left_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        dvld_d    = 1'b0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        case (state_q)
            IDLE: begin
                if (target_addr_in_valid) begin
                    addr_d = target_addr_in[MEM_ADDR_WIDTH-1:0];
                    cnt_d  = 16'd0;
                    if (!hit) begin
                        state_d = RESP_ERR;
                    end else if (target_rw) begin
                        state_d = WR_BURST;
                        // A beat presented together with the command is committed immediately.
                        if (target_data_in_valid) begin
                            mem_we    = 1'b1;
                            mem_waddr = target_addr_in[MEM_ADDR_WIDTH-1:0];
                            addr_d    = target_addr_in[MEM_ADDR_WIDTH-1:0] + 1'b1;
                            left_d    = {1'b0, target_burst_len};
                        end else begin
                            left_d    = {1'b0, target_burst_len} + 5'd1;
                        end
                    end else begin
                        left_d = {1'b0, target_burst_len};
                        if (READ_LATENCY > 1) begin
                            state_d = RD_WAIT;
                            cnt_d   = LAT_INIT;
                        end else begin
                            state_d = RD_BURST;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 16'd0) state_d = RD_BURST;
                else                cnt_d   = cnt_q - 16'd1;
            end
            RD_BURST: begin
                dout_d = mem[addr_q];
                dvld_d = 1'b1;
                addr_d = addr_q + 1'b1;
                if (left_q == 5'd0) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    left_d  = left_q - 5'd1;
                end
            end
            WR_BURST: begin
                if (left_q == 5'd0) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else if (target_data_in_valid) begin
                    mem_we  = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    left_d  = left_q - 5'd1;
                    cnt_d   = 16'd0;
                end else if (WR_TIMEOUT != 0 && (cnt_q + 16'd1) == TO_LIM) begin
                    // Master stalled too long: drop remaining beats and report an error.
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else if (WR_TIMEOUT != 0) begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            RESP_ERR: begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Storage is deliberately not reset so committed beats survive an abort.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= target_data_in;
    end

    assign target_data_out       = dout_q;
    assign target_data_out_valid = dvld_q;
    assign target_ack            = ack_q;
    assign target_err            = err_q;
    assign target_ready          = ready_q;

endmodule

// File: tb/tb_bus_target_burst.sv
// Directed bench for bus_target_burst: one instance with default parameters and one
// with READ_LATENCY=3, BASE_ADDR=16'h0100, WR_TIMEOUT=4.
module tb_bus_target_burst;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [15:0] addr0, addr1;
    logic        av0, av1, rw0, rw1, dv0, dv1;
    logic [3:0]  len0, len1;
    logic [7:0]  din0, din1;
    logic [7:0]  dout0, dout1;
    logic        dvld0, dvld1, ack0, ack1, err0, err1, rdy0, rdy1;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bus_target_burst u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr0), .target_addr_in_valid(av0), .target_rw(rw0),
        .target_burst_len(len0), .target_data_in(din0), .target_data_in_valid(dv0),
        .target_data_out(dout0), .target_data_out_valid(dvld0),
        .target_ack(ack0), .target_err(err0), .target_ready(rdy0)
    );

    bus_target_burst #(
        .DATA_WIDTH(8), .MEM_ADDR_WIDTH(8), .BASE_ADDR(16'h0100),
        .READ_LATENCY(3), .WR_TIMEOUT(4)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr1), .target_addr_in_valid(av1), .target_rw(rw1),
        .target_burst_len(len1), .target_data_in(din1), .target_data_in_valid(dv1),
        .target_data_out(dout1), .target_data_out_valid(dvld1),
        .target_ack(ack1), .target_err(err1), .target_ready(rdy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int d, input logic [15:0] a, input logic rw,
                       input logic [3:0] len, input logic [7:0] din, input logic dv);
        if (d == 0) begin
            addr0 = a; av0 = 1'b1; rw0 = rw; len0 = len; din0 = din; dv0 = dv;
        end else begin
            addr1 = a; av1 = 1'b1; rw1 = rw; len1 = len; din1 = din; dv1 = dv;
        end
    endtask

    task automatic dat(input int d, input logic [7:0] din, input logic dv);
        if (d == 0) begin
            av0 = 1'b0; din0 = din; dv0 = dv;
        end else begin
            av1 = 1'b0; din1 = din; dv1 = dv;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        total++;
        assert (o === e) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic obs(input int d, input string tag, input logic vld, input logic [7:0] dt,
                       input logic ack, input logic err, input logic rdy);
        logic [7:0] o_dout;
        logic       o_vld, o_ack, o_err, o_rdy;
        if (d == 0) begin
            o_dout = dout0; o_vld = dvld0; o_ack = ack0; o_err = err0; o_rdy = rdy0;
        end else begin
            o_dout = dout1; o_vld = dvld1; o_ack = ack1; o_err = err1; o_rdy = rdy1;
        end
        chk({tag, ".vld"},  {7'd0, o_vld}, {7'd0, vld});
        chk({tag, ".data"}, o_dout, dt);
        chk({tag, ".ack"},  {7'd0, o_ack}, {7'd0, ack});
        chk({tag, ".err"},  {7'd0, o_err}, {7'd0, err});
        chk({tag, ".rdy"},  {7'd0, o_rdy}, {7'd0, rdy});
    endtask

    initial begin
        logic [7:0] wexp [4];
        wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33; wexp[3] = 8'h44;

        rst_n = 1'b0;
        addr0 = '0; av0 = 1'b0; rw0 = 1'b0; len0 = '0; din0 = '0; dv0 = 1'b0;
        addr1 = '0; av1 = 1'b0; rw1 = 1'b0; len1 = '0; din1 = '0; dv1 = 1'b0;
        repeat (3) step();
        obs(0, "rst0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        obs(1, "rst1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();

        // Single write then read-after-write, latency 1
        cmd(0, 16'h0012, 1'b1, 4'd0, 8'hA5, 1'b1);
        step();
        obs(0, "w1_accept", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dat(0, 8'h00, 1'b0);
        step();
        obs(0, "w1_ack", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step();
        obs(0, "w1_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        cmd(0, 16'h0012, 1'b0, 4'd0, 8'h00, 1'b0);
        step();
        obs(0, "r1_accept", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dat(0, 8'h00, 1'b0);
        step();
        obs(0, "r1_beat", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1);
        step();
        obs(0, "r1_hold", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);

        // Wrapping write burst at 0xFE with a one-cycle gap
        cmd(0, 16'h00FE, 1'b1, 4'd3, 8'h11, 1'b1);
        step();
        dat(0, 8'h22, 1'b1);
        step();
        dat(0, 8'h00, 1'b0);
        step();
        dat(0, 8'h33, 1'b1);
        step();
        dat(0, 8'h44, 1'b1);
        step();
        obs(0, "wb_last", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        dat(0, 8'h00, 1'b0);
        step();
        obs(0, "wb_ack", 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1);

        cmd(0, 16'h00FE, 1'b0, 4'd3, 8'h00, 1'b0);
        step();
        dat(0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            obs(0, $sformatf("rb%0d", k), 1'b1, wexp[k], k == 3, 1'b0, k == 3);
        end
        step();
        obs(0, "rb_hold", 1'b0, 8'h44, 1'b0, 1'b0, 1'b1);

        cmd(0, 16'h0001, 1'b0, 4'd0, 8'h00, 1'b0);
        step();
        dat(0, 8'h00, 1'b0);
        step();
        obs(0, "rd_wrapped", 1'b1, 8'h44, 1'b1, 1'b0, 1'b1);

        // Latency-3 instance: 4-beat write then read
        cmd(1, 16'h0110, 1'b1, 4'd3, 8'h01, 1'b1);
        step();
        dat(1, 8'h02, 1'b1);
        step();
        dat(1, 8'h03, 1'b1);
        step();
        dat(1, 8'h04, 1'b1);
        step();
        dat(1, 8'h00, 1'b0);
        step();
        obs(1, "w4_ack", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        cmd(1, 16'h0110, 1'b0, 4'd3, 8'h00, 1'b0);
        step();
        obs(1, "r4_accept", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        dat(1, 8'h00, 1'b0);
        step();
        obs(1, "r4_wait1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        obs(1, "r4_wait2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            obs(1, $sformatf("r4_beat%0d", k), 1'b1, 8'(k + 1), k == 3, 1'b0, k == 3);
        end

        // Decode miss must not touch memory
        cmd(1, 16'h0210, 1'b1, 4'd0, 8'hEE, 1'b1);
        step();
        obs(1, "miss_accept", 1'b0, 8'h04, 1'b0, 1'b0, 1'b0);
        dat(1, 8'h00, 1'b0);
        step();
        obs(1, "miss_ack", 1'b0, 8'h04, 1'b1, 1'b1, 1'b1);
        step();
        obs(1, "miss_after", 1'b0, 8'h04, 1'b0, 1'b0, 1'b1);
        cmd(1, 16'h0110, 1'b0, 4'd0, 8'h00, 1'b0);
        step();
        dat(1, 8'h00, 1'b0);
        repeat (3) step();
        obs(1, "miss_mem", 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);

        // Write timeout: one beat then stall
        cmd(1, 16'h0130, 1'b1, 4'd1, 8'h77, 1'b1);
        step();
        dat(1, 8'h00, 1'b0);
        repeat (3) step();
        obs(1, "to_wait", 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        step();
        obs(1, "to_ack", 1'b0, 8'h01, 1'b1, 1'b1, 1'b1);
        step();
        obs(1, "to_after", 1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
        cmd(1, 16'h0130, 1'b0, 4'd0, 8'h00, 1'b0);
        step();
        dat(1, 8'h00, 1'b0);
        repeat (3) step();
        obs(1, "to_mem", 1'b1, 8'h77, 1'b1, 1'b0, 1'b1);

        // Reset during a read burst, then a fresh read
        cmd(1, 16'h0110, 1'b0, 4'd3, 8'h00, 1'b0);
        step();
        dat(1, 8'h00, 1'b0);
        repeat (3) step();
        obs(1, "rst_b0", 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        obs(1, "rst_async", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        obs(1, "rst_held", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        cmd(1, 16'h0111, 1'b0, 4'd0, 8'h00, 1'b0);
        step();
        dat(1, 8'h00, 1'b0);
        repeat (3) step();
        obs(1, "post_rst", 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
